// File: rtl/uart_tx_feeder.sv
// Byte FIFO and sequencer in front of the Uart8 transmitter: queues bytes at clk rate,
// presents one at a time on txByte/txStart and pops it on the rising edge of txDone.
module uart_tx_feeder #(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  wrEn,
  input  logic [7:0]            wrData,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  txEn,
  output logic                  txStart,
  output logic [7:0]            txByte,
  input  logic                  txBusy,
  input  logic                  txDone
);

  typedef enum logic [1:0] {IDLE, START, BUSY} state_t;

  state_t                state;
  logic [7:0]            mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] rd_next;
  logic                  done_q;
  logic                  done_rise;
  logic                  pop;
  logic                  push;
  logic [ADDR_WIDTH:0]   count_next;
  logic [7:0]            next_head;

  // A byte written in the same cycle it becomes the new head is forwarded directly,
  // since the memory copy is not visible until the following cycle.
  always_comb begin
    done_rise  = txDone & ~done_q;
    pop        = (state == BUSY) & done_rise;
    push       = wrEn & (~full | pop);
    rd_next    = rd_ptr + 1'b1;
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
    if (push && (wr_ptr == rd_next))
      next_head = wrData;
    else
      next_head = mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= wrData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      done_q   <= 1'b0;
      txEn     <= 1'b0;
      txStart  <= 1'b0;
      txByte   <= 8'h00;
    end else begin
      done_q   <= txDone;
      txEn     <= enable;
      overflow <= wrEn & ~push;
      count    <= count_next;
      empty    <= (count_next == '0);
      full     <= (count_next == (ADDR_WIDTH+1)'(DEPTH));
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_next;

      case (state)
        IDLE: begin
          txStart <= 1'b0;
          if (enable && !empty) begin
            state   <= START;
            txStart <= 1'b1;
            txByte  <= mem[rd_ptr];
          end
        end
        START: begin
          if (txBusy) begin
            state   <= BUSY;
            txStart <= 1'b0;
          end
        end
        BUSY: begin
          txStart <= 1'b0;
          if (pop) begin
            if (enable && (count_next != '0)) begin
              state   <= START;
              txStart <= 1'b1;
              txByte  <= next_head;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state   <= IDLE;
          txStart <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: a byte-level queue model plus a simple Uart8
// stand-in that answers txStart with a busy window followed by a txDone pulse.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int FRAME = 20;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       enable = 1'b0;
  logic       wrEn   = 1'b0;
  logic [7:0] wrData = 8'h00;
  logic       full, empty, overflow, txEn, txStart;
  logic [4:0] count;
  logic [7:0] txByte;
  logic       txBusy, txDone;

  logic uart_busy = 1'b0;
  logic uart_done = 1'b0;
  logic man_done  = 1'b0;
  assign txBusy = uart_busy;
  assign txDone = uart_done | man_done;

  int vectors     = 0;
  int miscompares = 0;
  int uart_cnt    = 0;
  int done_hold   = 3;
  int ovf_seen    = 0;
  bit checking    = 1'b0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] t2data [20] = '{8'd30, 8'd24, 8'd19, 8'd25, 8'd91, 8'd77, 8'd1, 8'd0, 8'd99, 8'd15,
                              8'd100, 8'd128, 8'd255, 8'd254, 8'd0, 8'd10, 8'd43, 8'd149, 8'd7, 8'd2};

  uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wrEn(wrEn), .wrData(wrData),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .txEn(txEn), .txStart(txStart), .txByte(txByte), .txBusy(txBusy), .txDone(txDone)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Uart8 stand-in: latches txByte when it goes busy, later drops busy and holds txDone.
  always @(negedge clk) begin
    if (uart_cnt == 0) begin
      if (txStart === 1'b1) uart_cnt = 1;
    end else begin
      uart_cnt++;
      if (uart_cnt == 3) begin
        uart_busy = 1'b1;
        rx_q.push_back(txByte);
      end else if (uart_cnt == 3 + FRAME) begin
        uart_busy = 1'b0;
        uart_done = 1'b1;
      end else if (uart_cnt == 3 + FRAME + done_hold) begin
        uart_done = 1'b0;
        uart_cnt  = 0;
      end
    end
  end

  // Queue model: a byte handed to the UART leaves the queue on the next rising txDone.
  logic [7:0] mq[$];
  bit handed = 1'b0, prev_done = 1'b0, exp_ovf = 1'b0, exp_en = 1'b0;
  bit m_pop, m_acc;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      handed    = 1'b0;
      prev_done = 1'b0;
      exp_ovf   = 1'b0;
      exp_en    = 1'b0;
    end else begin
      m_pop   = handed && (txDone === 1'b1) && !prev_done;
      m_acc   = (wrEn === 1'b1) && ((mq.size() < DEPTH) || m_pop);
      exp_ovf = (wrEn === 1'b1) && !m_acc;
      if (m_pop) begin
        void'(mq.pop_front());
        handed = 1'b0;
      end
      if (m_acc) mq.push_back(wrData);
      if (txStart === 1'b1 && txBusy === 1'b1) handed = 1'b1;
      prev_done = (txDone === 1'b1);
      exp_en    = (enable === 1'b1);
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("count", count, mq.size());
      checkOutput("empty", empty, mq.size() == 0);
      checkOutput("full", full, mq.size() == DEPTH);
      checkOutput("overflow", overflow, exp_ovf);
      checkOutput("txEn", txEn, exp_en);
      if (txStart === 1'b1) begin
        if (mq.size() == 0) checkOutput("start_on_empty", mq.size(), 1);
        else checkOutput("txByte_head", txByte, mq[0]);
      end
    end
    if (overflow === 1'b1) ovf_seen++;
  end

  task automatic applyStimulus(input bit we, input logic [7:0] d, input bit en);
    @(negedge clk);
    #1;
    wrEn   = we;
    wrData = d;
    enable = en;
  endtask

  task automatic waitRx(input string name, input int n);
    int i = 0;
    while (rx_q.size() < n && i < 3000) begin @(negedge clk); #1; i++; end
    checkOutput({name, "_rx_count"}, rx_q.size(), n);
  endtask

  task automatic waitDrained(input string name);
    int i = 0;
    while ((count !== 5'd0 || uart_cnt != 0) && i < 3000) begin @(negedge clk); #1; i++; end
    checkOutput({name, "_drained"}, count, 0);
  endtask

  task automatic checkRx(input string name);
    checkOutput({name, "_rx_len"}, rx_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < rx_q.size()) checkOutput($sformatf("%s_rx%0d", name, i), rx_q[i], exp_q[i]);
  endtask

  initial begin
    int i;
    int starts;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_txStart", txStart, 0);
    checkOutput("rst_txByte", txByte, 8'h00);
    checkOutput("rst_count", count, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_txEn", txEn, 0);
    checkOutput("rst_overflow", overflow, 0);
    #1 rst = 1'b0;
    checking = 1'b1;

    // Test 1: single byte latency
    rx_q.delete();
    applyStimulus(0, 8'h00, 1);
    applyStimulus(1, 8'h1E, 1);
    applyStimulus(0, 8'h00, 1);
    checkOutput("t1_start_n", txStart, 0);
    checkOutput("t1_count", count, 1);
    checkOutput("t1_txEn", txEn, 1);
    applyStimulus(0, 8'h00, 1);
    checkOutput("t1_start_n1", txStart, 1);
    checkOutput("t1_txByte", txByte, 8'h1E);
    waitRx("t1", 1);
    waitDrained("t1");
    exp_q.delete(); exp_q.push_back(8'h1E);
    checkRx("t1");

    // Test 2: 20 back-to-back writes into a 16-deep queue
    rx_q.delete();
    ovf_seen = 0;
    for (int k = 0; k < 20; k++) applyStimulus(1, t2data[k], 1);
    applyStimulus(0, 8'h00, 1);
    checkOutput("t2_full", full, 1);
    checkOutput("t2_count16", count, 16);
    checkOutput("t2_overflow_pulses", ovf_seen, 4);
    waitDrained("t2");
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back(t2data[k]);
    checkRx("t2");
    checkOutput("t2_empty", empty, 1);

    // Test 3: write while full on the exact pop cycle
    rx_q.delete();
    exp_q.delete();
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1, 8'h40 + 8'(k), 1);
      exp_q.push_back(8'h40 + 8'(k));
    end
    applyStimulus(0, 8'h00, 1);
    i = 0;
    while (uart_done !== 1'b1 && i < 1000) begin @(negedge clk); #1; i++; end
    checkOutput("t3_done_seen", uart_done, 1);
    checkOutput("t3_full_before", count, 16);
    wrEn = 1'b1; wrData = 8'hEE;
    exp_q.push_back(8'hEE);
    applyStimulus(0, 8'h00, 1);
    checkOutput("t3_count_stays", count, 16);
    checkOutput("t3_no_overflow", overflow, 0);
    waitDrained("t3");
    checkRx("t3");

    // Test 4a: txDone held 50 cycles yields exactly one pop
    rx_q.delete();
    done_hold = 50;
    applyStimulus(1, 8'h11, 1);
    applyStimulus(1, 8'h22, 1);
    applyStimulus(0, 8'h00, 1);
    i = 0;
    while (uart_done !== 1'b1 && i < 1000) begin @(negedge clk); #1; i++; end
    repeat (10) begin @(negedge clk); #1; end
    checkOutput("t4_one_pop", count, 1);
    waitDrained("t4a");
    done_hold = 3;
    exp_q.delete(); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    checkRx("t4a");

    // Test 4b: txDone pulse while idle is ignored
    rx_q.delete();
    applyStimulus(1, 8'h33, 0);
    applyStimulus(1, 8'h44, 0);
    applyStimulus(0, 8'h00, 0);
    @(negedge clk); #1 man_done = 1'b1;
    @(negedge clk); #1 man_done = 1'b0;
    repeat (2) begin @(negedge clk); #1; end
    checkOutput("t4_idle_done_count", count, 2);
    applyStimulus(0, 8'h00, 1);
    waitDrained("t4b");
    exp_q.delete(); exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    checkRx("t4b");

    // Test 5: enable dropped during byte 1
    rx_q.delete();
    applyStimulus(1, 8'h51, 1);
    applyStimulus(1, 8'h52, 1);
    applyStimulus(1, 8'h53, 1);
    applyStimulus(0, 8'h00, 1);
    waitRx("t5a", 1);
    applyStimulus(0, 8'h00, 0);
    i = 0;
    while (count !== 5'd2 && i < 1000) begin @(negedge clk); #1; i++; end
    starts = 0;
    repeat (30) begin @(negedge clk); #1; if (txStart === 1'b1) starts++; end
    checkOutput("t5_no_restart", starts, 0);
    checkOutput("t5_count", count, 2);
    checkOutput("t5_rx_one", rx_q.size(), 1);
    applyStimulus(0, 8'h00, 1);
    waitDrained("t5");
    exp_q.delete(); exp_q.push_back(8'h51); exp_q.push_back(8'h52); exp_q.push_back(8'h53);
    checkRx("t5");

    // Test 6: reset during byte 2 of 4
    rx_q.delete();
    for (int k = 0; k < 4; k++) applyStimulus(1, 8'h61 + 8'(k), 1);
    applyStimulus(0, 8'h00, 1);
    waitRx("t6a", 2);
    checkOutput("t6_count_before", count, 3);
    rst = 1'b1;
    #1;
    checkOutput("t6_txStart_async", txStart, 0);
    checkOutput("t6_count_async", count, 0);
    checkOutput("t6_empty_async", empty, 1);
    @(negedge clk); #1;
    @(negedge clk); #1 rst = 1'b0;
    i = 0;
    while (uart_done !== 1'b1 && i < 1000) begin @(negedge clk); #1; i++; end
    checkOutput("t6_stale_done", uart_done, 1);
    waitDrained("t6a");
    checkOutput("t6_no_pop", count, 0);
    applyStimulus(1, 8'hA5, 1);
    applyStimulus(0, 8'h00, 1);
    waitRx("t6b", 3);
    waitDrained("t6b");
    if (rx_q.size() == 3) checkOutput("t6_a5", rx_q[2], 8'hA5);
    else checkOutput("t6_a5_len", rx_q.size(), 3);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
